// File: rtl/cache_mem_responder_pkg.sv
// Shared encodings for the cache <-> memory responder link: transfer types and FSM states.
package cache_mem_responder_pkg;

    typedef enum logic [2:0] {
        MT_BYTE = 3'b000,
        MT_HALF = 3'b001,
        MT_WORD = 3'b010,
        MT_LINE = 3'b100
    } mem_type_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_e;

    localparam int LINE_WORDS = 4;

    // Only the line code changes behaviour; every other code, listed or not, is a one-word access.
    function automatic logic is_line(input logic [2:0] t);
        return t == MT_LINE;
    endfunction

endpackage

// File: rtl/cache_mem_responder_ram.sv
// Word-organised backing store: byte-enabled write port covering one 4-word line,
// and an asynchronous 4-word line read port.
module resp_ram #(
    parameter int MEM_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic                           wr_line,
    input  logic [$clog2(MEM_WORDS)-1:0]   wr_idx,
    input  logic [3:0]                     wr_wstrb,
    input  logic [127:0]                   wr_data,
    input  logic [$clog2(MEM_WORDS)-3:0]   rd_line_idx,
    output logic [127:0]                   rd_line
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];
    logic [3:0]  word_be [4];
    logic [31:0] word_wd [4];

    // A line write enables every byte of all four words; a single-word write
    // only touches the word selected by wr_idx[1:0].
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            word_be[k] = 4'h0;
            word_wd[k] = wr_data[31:0];
            if (wr_line) begin
                word_be[k] = 4'hF;
                word_wd[k] = wr_data[32*k +: 32];
            end else if (wr_idx[1:0] == 2'(k)) begin
                word_be[k] = wr_wstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (word_be[k][b]) begin
                        mem[{wr_idx[AW-1:2], 2'(k)}][8*b +: 8] <= word_wd[k][8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_line = '0;
        for (int k = 0; k < 4; k++) begin
            rd_line[32*k +: 32] = mem[{rd_line_idx, 2'(k)}];
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache: fixed-latency reads (word or 4-beat line)
// and writes that hold off further writes for WR_LATENCY cycles.
//
// state  | meaning
// R_IDLE | no read outstanding; rd_rdy unless a write is being accepted
// R_WAIT | read accepted, line latched, counting down the read latency
// R_RESP | driving return beats (1 for word types, 4 for line)
// W_IDLE | wr_rdy high, a write may be accepted
// W_BUSY | write done, wr_rdy held low for WR_LATENCY cycles
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int RCW = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam int WCW = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;
    localparam logic [RCW-1:0] RD_LOAD = RCW'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [WCW-1:0] WR_LOAD = WCW'((WR_LATENCY > 0) ? WR_LATENCY - 1 : 0);

    rd_state_e      rd_state, rd_state_nx;
    wr_state_e      wr_state, wr_state_nx;
    logic           rd_accept, wr_accept;
    logic [RCW-1:0] rd_cnt;
    logic [WCW-1:0] wr_cnt;
    logic [1:0]     beat;
    logic           line_rd;
    logic [1:0]     word_sel;
    logic [31:0]    ret_buf [4];
    logic [127:0]   ram_line;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

    // Write wins a same-cycle collision, so the read is held off via rd_rdy.
    assign wr_rdy    = (wr_state == W_IDLE);
    assign wr_accept = resetn && wr_req && wr_rdy;
    assign rd_rdy    = (rd_state == R_IDLE) && !(wr_req && wr_rdy);
    assign rd_accept = resetn && rd_req && rd_rdy;

    resp_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
        .clk         (clk),
        .wr_en       (wr_accept),
        .wr_line     (is_line(wr_type)),
        .wr_idx      (wr_addr[AW+1:2]),
        .wr_wstrb    (wr_wstrb),
        .wr_data     (wr_data),
        .rd_line_idx (rd_addr[AW+1:4]),
        .rd_line     (ram_line)
    );

    always_comb begin
        rd_state_nx = rd_state;
        ret_valid   = 1'b0;
        ret_last    = 1'b0;
        ret_data    = '0;
        case (rd_state)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_state_nx = (RD_LATENCY > 1) ? R_WAIT : R_RESP;
                end
            end
            R_WAIT: begin
                if (rd_cnt == '0) begin
                    rd_state_nx = R_RESP;
                end
            end
            R_RESP: begin
                ret_valid = resetn;
                ret_last  = resetn && (!line_rd || beat == 2'd3);
                ret_data  = resetn ? ret_buf[line_rd ? beat : word_sel] : '0;
                if (ret_last) begin
                    rd_state_nx = R_IDLE;
                end
            end
            default: rd_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
            beat     <= '0;
        end else begin
            rd_state <= rd_state_nx;
            if (rd_accept) begin
                rd_cnt <= RD_LOAD;
            end else if (rd_state == R_WAIT && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - RCW'(1);
            end
            if (rd_accept) begin
                beat <= '0;
            end else if (rd_state == R_RESP) begin
                beat <= beat + 2'd1;
            end
        end
    end

    // Snapshot of the line at acceptance; later writes cannot disturb the beats.
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                ret_buf[k] <= ram_line[32*k +: 32];
            end
            line_rd  <= is_line(rd_type);
            word_sel <= rd_addr[3:2];
        end
    end

    always_comb begin
        wr_state_nx = wr_state;
        case (wr_state)
            W_IDLE:  if (wr_accept) wr_state_nx = W_BUSY;
            W_BUSY:  if (wr_cnt == '0) wr_state_nx = W_IDLE;
            default: wr_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_state <= W_IDLE;
            wr_cnt   <= '0;
        end else begin
            wr_state <= wr_state_nx;
            if (wr_accept) begin
                wr_cnt <= WR_LOAD;
            end else if (wr_state == W_BUSY && wr_cnt != '0) begin
                wr_cnt <= wr_cnt - WCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed vector table, multi-cycle
// corner sequences, and random traffic against a word-array reference model.
module tb_cache_mem_responder;

    localparam int MW     = 1024;
    localparam int RD_LAT = 2;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [MW];

    typedef struct {
        logic         is_wr;
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   strb;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    cache_mem_responder #(.MEM_WORDS(MW), .RD_LATENCY(RD_LAT), .WR_LATENCY(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_write(input logic [2:0] t, input logic [31:0] a,
                                        input logic [3:0] s, input logic [127:0] d);
        int idx;
        int base;
        idx  = int'((a >> 2) % MW);
        base = idx - (idx % 4);
        if (t == 3'b100) begin
            for (int k = 0; k < 4; k++) model_mem[base + k] = d[32*k +: 32];
        end else begin
            for (int b = 0; b < 4; b++) if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic logic [127:0] model_read(input logic [2:0] t, input logic [31:0] a);
        logic [127:0] r;
        int idx;
        int base;
        idx  = int'((a >> 2) % MW);
        base = idx - (idx % 4);
        r    = '0;
        if (t == 3'b100) begin
            for (int k = 0; k < 4; k++) r[32*k +: 32] = model_mem[base + k];
        end else begin
            r[31:0] = model_mem[idx];
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts just after the acceptance edge: w quiet cycles, nb beats, then quiet.
    task automatic collect(input int w, input int nb, input logic [127:0] exp, input string nm);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            chk({nm, "_wait"}, {ret_valid, ret_last, ret_data}, '0);
        end
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            chk($sformatf("%s_beat%0d", nm, b), {ret_valid, ret_last, ret_data},
                {1'b1, (b == nb - 1), exp[32*b +: 32]});
        end
        @(negedge clk);
        chk({nm, "_after"}, {ret_valid, ret_last, ret_data}, '0);
    endtask

    task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                            input logic [127:0] d);
        int n;
        @(negedge clk);
        wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
        #1;
        n = 0;
        while (!wr_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("wr_rdy_timeout", 1'b1, 1'b0);
            wr_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        model_write(t, a, s, d);
    endtask

    task automatic do_read(input logic [2:0] t, input logic [31:0] a, input logic [127:0] exp,
                           input string nm);
        int n;
        @(negedge clk);
        rd_req = 1'b1; rd_type = t; rd_addr = a;
        #1;
        n = 0;
        while (!rd_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk({nm, "_rd_rdy_timeout"}, 1'b1, 1'b0);
            rd_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        collect(RD_LAT - 1, (t == 3'b100) ? 4 : 1, exp, nm);
    endtask

    initial begin
        logic [2:0]   tys [6];
        logic [2:0]   t;
        logic [31:0]  a;
        logic [127:0] d;
        logic [127:0] exp_old;
        logic         saw;

        tys[0] = 3'b000; tys[1] = 3'b001; tys[2] = 3'b010;
        tys[3] = 3'b100; tys[4] = 3'b011; tys[5] = 3'b101;

        vec[0]  = '{1'b1, 3'b100, 32'h0000_0100, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11}, '0};
        vec[1]  = '{1'b0, 3'b100, 32'h0000_0104, 4'h0, '0, {32'h44, 32'h33, 32'h22, 32'h11}};
        vec[2]  = '{1'b1, 3'b010, 32'h0000_0020, 4'hF, '0, '0};
        vec[3]  = '{1'b1, 3'b010, 32'h0000_0020, 4'b0101, 128'hAABB_CCDD, '0};
        vec[4]  = '{1'b0, 3'b010, 32'h0000_0020, 4'h0, '0, 128'h00BB_00DD};
        vec[5]  = '{1'b1, 3'b010, 32'h0000_1000, 4'hF, 128'h1234_5678, '0};
        vec[6]  = '{1'b0, 3'b010, 32'h0000_0000, 4'h0, '0, 128'h1234_5678};
        vec[7]  = '{1'b0, 3'b000, 32'h0000_0103, 4'h0, '0, 128'h11};
        vec[8]  = '{1'b0, 3'b011, 32'h0000_010A, 4'h0, '0, 128'h33};
        vec[9]  = '{1'b1, 3'b101, 32'h0000_010C, 4'b1000, 128'hEE00_0000, '0};
        vec[10] = '{1'b0, 3'b100, 32'h0000_010F, 4'h0, '0, {32'hEE00_0044, 32'h33, 32'h22, 32'h11}};
        vec[11] = '{1'b0, 3'b001, 32'hABCD_0102, 4'h0, '0, 128'h11};

        resetn = 1'b0; rd_req = 1'b0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;

        repeat (2) @(negedge clk);
        chk("reset_rdy", {rd_rdy, wr_rdy}, 2'b11);
        chk("reset_ret", {ret_valid, ret_last, ret_data}, '0);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_rdy", {rd_rdy, wr_rdy}, 2'b11);

        for (int i = 0; i < MW / 4; i++) do_write(3'b100, 32'(i * 16), 4'h0, '0);
        for (int i = 0; i < MW; i++) model_mem[i] = '0;

        for (int i = 0; i < NV; i++) begin
            if (vec[i].is_wr) do_write(vec[i].typ, vec[i].addr, vec[i].strb, vec[i].wdata);
            else do_read(vec[i].typ, vec[i].addr, vec[i].exp, $sformatf("vec%0d", i));
        end

        // Simultaneous read and write: write first, read one cycle later sees new data.
        idle(4);
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h40; wr_wstrb = 4'hF; wr_data = 128'h5A5A_1234;
        rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h40;
        #1;
        chk("coll_rdy", {wr_rdy, rd_rdy}, 2'b10);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        model_write(3'b010, 32'h40, 4'hF, 128'h5A5A_1234);
        @(negedge clk);
        chk("coll_rd_rdy_next", rd_rdy, 1'b1);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        collect(RD_LAT - 1, 1, 128'h5A5A_1234, "coll_rd");

        // Back-to-back writes: wr_rdy low for exactly two cycles.
        idle(4);
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h80; wr_wstrb = 4'hF; wr_data = 128'h1111_0000;
        #1;
        chk("b2b_rdy0", wr_rdy, 1'b1);
        @(posedge clk);
        #1;
        model_write(3'b010, 32'h80, 4'hF, 128'h1111_0000);
        wr_addr = 32'h84; wr_data = 128'h2222_0000;
        @(negedge clk);
        chk("b2b_busy1", wr_rdy, 1'b0);
        @(negedge clk);
        chk("b2b_busy2", wr_rdy, 1'b0);
        @(negedge clk);
        chk("b2b_ready3", wr_rdy, 1'b1);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        model_write(3'b010, 32'h84, 4'hF, 128'h2222_0000);
        do_read(3'b010, 32'h80, model_read(3'b010, 32'h80), "b2b_rd0");
        do_read(3'b010, 32'h84, model_read(3'b010, 32'h84), "b2b_rd1");

        // Write landing during R_WAIT must not alter the in-flight line.
        do_write(3'b100, 32'h200, 4'h0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        idle(4);
        exp_old = model_read(3'b100, 32'h208);
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h208;
        #1;
        chk("infl_rd_rdy", rd_rdy, 1'b1);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h200; wr_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        @(negedge clk);
        chk("infl_wr_rdy", {wr_rdy, ret_valid}, 2'b10);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        model_write(3'b100, 32'h200, 4'h0, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        collect(RD_LAT - 2, 4, exp_old, "infl_rd");
        do_read(3'b100, 32'h20C, model_read(3'b100, 32'h20C), "infl_reread");

        // Reset during R_WAIT abandons the read and leaves memory intact.
        idle(4);
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h100;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rst_mid_state", {rd_rdy, wr_rdy, ret_valid}, 3'b110);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ret_valid) saw = 1'b1;
        end
        chk("rst_mid_no_ret", saw, 1'b0);
        do_read(3'b100, 32'h100, model_read(3'b100, 32'h100), "rst_reread");

        for (int i = 0; i < 80; i++) begin
            t = tys[$urandom_range(0, 5)];
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                do_write(t, a, 4'($urandom_range(0, 15)), d);
            end else begin
                do_read(t, a, model_read(t, a), $sformatf("rand%0d", i));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter RD_LATENCY, default 2, the cycles from read acceptance to first ret_valid (minimum 1).
REQ-003 SHALL have parameter WR_LATENCY, default 2, the cycles wr_rdy stays low after a write is accepted (minimum 1).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 rd_req  input  1  read request from the cache.
REQ-007 rd_type  input  3  read type: 000 byte, 001 half, 010 word, 100 line.
REQ-008 rd_addr  input  32  read byte address.
REQ-009 rd_rdy  output  1  read request can be accepted this cycle.
REQ-010 ret_valid  output  1  read return beat valid.
REQ-011 ret_last  output  1  final beat of a read return.
REQ-012 ret_data  output  32  read return data.
REQ-013 wr_req  input  1  write request from the cache.
REQ-014 wr_type  input  3  write type, same encoding as rd_type.
REQ-015 wr_addr  input  32  write byte address.
REQ-016 wr_wstrb  input  4  byte enables for non-line writes.
REQ-017 wr_data  input  128  write data; word k in bits [32k+31:32k].
REQ-018 wr_rdy  output  1  write request can be accepted this cycle.

Function
REQ-019 Word index SHALL be addr[log2(MEM_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo MEM_WORDS words.
REQ-020 A read SHALL be accepted on the rising edge where rd_req=1 and rd_rdy=1; rd_type and rd_addr are captured on that edge.
REQ-021 rd_rdy SHALL be 1 only when the read FSM is R_IDLE and no write is being accepted in the same cycle.
REQ-022 Read FSM states SHALL be R_IDLE, R_WAIT and R_RESP.
REQ-023 Read FSM transitions SHALL be: R_IDLE->R_WAIT on acceptance; R_WAIT->R_RESP after RD_LATENCY-1 cycles in R_WAIT; R_RESP->R_IDLE after the beat with ret_last=1.
REQ-024 The first ret_valid SHALL occur exactly RD_LATENCY cycles after the acceptance edge.
REQ-025 A line read (100) SHALL return 4 beats on consecutive cycles, with no stalls.
REQ-026 Line-read beat k (k=0..3) SHALL carry the word at (addr aligned to 16 bytes) + 4k.
REQ-027 ret_last SHALL be 1 only on beat 3 of a line read.
REQ-028 Reads of type 000, 001 or 010 SHALL return 1 beat with ret_last=1, carrying the full aligned 32-bit word containing rd_addr.
REQ-029 ret_valid and ret_last SHALL be 0 outside R_RESP; ret_data SHALL be 0 whenever ret_valid=0.
REQ-030 A write SHALL be accepted on the rising edge where wr_req=1 and wr_rdy=1; memory SHALL be updated on that same edge.
REQ-031 A line write SHALL write all 4 words of the 16-byte-aligned line, with all bytes enabled and wr_wstrb ignored.
REQ-032 Any other write type SHALL write only word index(wr_addr) from wr_data[31:0], and only the bytes enabled by wr_wstrb.
REQ-033 Write FSM states SHALL be W_IDLE and W_BUSY; wr_rdy SHALL be 1 only in W_IDLE.
REQ-034 After a write is accepted, the write FSM SHALL stay in W_BUSY for WR_LATENCY cycles, then return to W_IDLE.
REQ-035 When rd_req and wr_req are both asserted in R_IDLE/W_IDLE, the write SHALL take priority and the read SHALL be accepted on a later cycle.
REQ-036 Any read accepted after a write's acceptance edge SHALL return the written data.
REQ-037 A write SHALL be acceptable while a read is in R_WAIT or R_RESP.
REQ-038 A read in flight SHALL return memory contents as of its acceptance edge, so later writes do not alter the beats.
REQ-039 An unlisted type code (011, 101, 110, 111) SHALL be treated as word (010).

Reset
REQ-040 While resetn=0 at a rising edge, both FSMs SHALL go to idle, rd_rdy/wr_rdy SHALL read 1 from the following cycle, and ret_valid/ret_last/ret_data SHALL be 0.
REQ-041 Reset mid-transfer SHALL abandon any outstanding read, with no further ret_valid, and SHALL leave memory contents unchanged (memory is not reset).

Structure
REQ-042 Type encodings (byte, half, word, line) and FSM state encodings SHALL live in a shared package also used by the cache.
REQ-043 A single sub-module resp_ram SHALL hold the MEM_WORDS x 32 array, with a byte-enabled write port and a 4-word line read port.
REQ-044 The read FSM SHALL latch the 4-word line into a return buffer at acceptance.

Verification
REQ-045 Line write at addr 0x100, data {0x44,0x33,0x22,0x11}, then line read of 0x104 -> accepted; beats 0x11,0x22,0x33,0x44 at acceptance+2..+5; ret_last on beat 4.
REQ-046 Word 0x0000_0000 at 0x20; word write to 0x20, wstrb=0101, data 0xAABBCCDD; word read of 0x20 -> single beat 0x00BB00DD, ret_last=1.
REQ-047 rd_req and wr_req asserted together with both FSMs idle -> write accepted and rd_rdy=0 that cycle; read accepted the next cycle and returns the new data.
REQ-048 Write to 0x1000 with MEM_WORDS=1024 -> data aliases to 0x0; read of 0x0 returns it.
REQ-049 Line read accepted, resetn=0 for one cycle during R_WAIT -> no ret_valid ever, rd_rdy=1 the cycle after reset releases, and memory intact on re-read.
REQ-050 Write accepted, then wr_req held high -> wr_rdy=0 for exactly 2 cycles, and the second write is accepted on the 3rd edge.
